// File: rtl/mips_fetch_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM states, next-PC select
// codes, the NOP encoding and the jump-offset helper.
package mips_fetch_stage_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_HOLD = 2'd3
    } fetch_state_e;

    typedef enum logic [1:0] {
        NPC_SEQ = 2'd0,
        NPC_BR  = 2'd1,
        NPC_JMP = 2'd2
    } npc_sel_e;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    // Low 28 bits of a J-type target: word index shifted to a byte address.
    function automatic logic [27:0] jmp_offset(input logic [25:0] index);
        return {index, 2'b00};
    endfunction

endpackage

// File: rtl/mips_fetch_stage_pc_gen.sv
// Combinational next-PC generator: sequential increment, branch target or
// jump target, with branch taking priority over jump.
module fetch_pc_gen
    import mips_fetch_stage_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int PC_INC = 4
) (
    input  logic [ADDR_W-1:0] pc,
    input  logic [ADDR_W-1:0] id_pc4,
    input  logic              br_taken_i,
    input  logic [ADDR_W-1:0] br_target_i,
    input  logic              jmp_en_i,
    input  logic [25:0]       jmp_index_i,
    output logic [ADDR_W-1:0] next_pc,
    output logic              redirect
);

    localparam logic [ADDR_W-1:0] HI_MASK    = ~ADDR_W'(28'hFFF_FFFF);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(2'b11);

    npc_sel_e          sel_s;
    logic [ADDR_W-1:0] seq_pc_s;
    logic [ADDR_W-1:0] br_pc_s;
    logic [ADDR_W-1:0] jmp_pc_s;

    // Adds wrap modulo 2^ADDR_W; targets are forced word-aligned.
    assign seq_pc_s = pc + ADDR_W'(PC_INC);
    assign br_pc_s  = br_target_i & ALIGN_MASK;
    assign jmp_pc_s = (id_pc4 & HI_MASK) | ADDR_W'(jmp_offset(jmp_index_i));

    // Redirect priority select
    always_comb begin
        sel_s = NPC_SEQ;
        if (br_taken_i) begin
            sel_s = NPC_BR;
        end else if (jmp_en_i) begin
            sel_s = NPC_JMP;
        end else begin
            sel_s = NPC_SEQ;
        end
    end

    // Next-PC mux
    always_comb begin
        next_pc = seq_pc_s;
        case (sel_s)
            NPC_SEQ: next_pc = seq_pc_s;
            NPC_BR:  next_pc = br_pc_s;
            NPC_JMP: next_pc = jmp_pc_s;
            default: next_pc = seq_pc_s;
        endcase
    end

    assign redirect = (sel_s != NPC_SEQ);

endmodule

// File: rtl/mips_fetch_stage.sv
// Instruction-fetch front end: PC register, single-outstanding imem handshake,
// hold buffer for decode stalls and the IF/ID pipeline register.
module mips_fetch_stage
    import mips_fetch_stage_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter int                INSTR_W  = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}},
    parameter int                PC_INC   = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_rvalid,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               stall_i,
    input  logic               br_taken_i,
    input  logic [ADDR_W-1:0]  br_target_i,
    input  logic               jmp_en_i,
    input  logic [25:0]        jmp_index_i,
    output logic               id_valid,
    output logic [INSTR_W-1:0] id_instr,
    output logic [ADDR_W-1:0]  id_pc,
    output logic [ADDR_W-1:0]  id_pc4
);

    fetch_state_e       state_r;
    fetch_state_e       state_nxt_s;
    logic [ADDR_W-1:0]  pc_r;
    logic [ADDR_W-1:0]  pc_nxt_s;
    logic [ADDR_W-1:0]  npc_s;
    logic               redirect_s;
    logic               kill_r;
    logic               kill_nxt_s;
    logic               hold_valid_r;
    logic [INSTR_W-1:0] hold_instr_r;
    logic               imem_req_r;
    logic [ADDR_W-1:0]  imem_addr_r;
    logic               id_valid_r;
    logic [INSTR_W-1:0] id_instr_r;
    logic [ADDR_W-1:0]  id_pc_r;
    logic [ADDR_W-1:0]  id_pc4_r;

    logic               rsp_s;
    logic               accept_s;
    logic               capture_s;
    logic               hold_load_s;
    logic               release_s;
    logic               id_load_s;
    logic [INSTR_W-1:0] id_data_s;

    fetch_pc_gen #(
        .ADDR_W (ADDR_W),
        .PC_INC (PC_INC)
    ) u_pc_gen (
        .pc          (pc_r),
        .id_pc4      (id_pc4_r),
        .br_taken_i  (br_taken_i),
        .br_target_i (br_target_i),
        .jmp_en_i    (jmp_en_i),
        .jmp_index_i (jmp_index_i),
        .next_pc     (npc_s),
        .redirect    (redirect_s)
    );

    // A response is only meaningful in S_WAIT; a redirect in the same cycle drops it.
    assign rsp_s       = (state_r == S_WAIT) && imem_rvalid;
    assign accept_s    = rsp_s && !kill_r && !redirect_s;
    assign capture_s   = accept_s && !stall_i;
    assign hold_load_s = accept_s && stall_i;
    assign release_s   = (state_r == S_HOLD) && hold_valid_r && !stall_i && !redirect_s;
    assign id_load_s   = capture_s || release_s;

    // IF/ID data source: fresh memory word or the parked hold-buffer word
    always_comb begin
        id_data_s = imem_rdata;
        if (release_s) begin
            id_data_s = hold_instr_r;
        end else begin
            id_data_s = imem_rdata;
        end
    end

    // PC advances only when an instruction enters IF/ID, or jumps on a redirect
    always_comb begin
        pc_nxt_s = pc_r;
        if (redirect_s) begin
            pc_nxt_s = npc_s;
        end else if (id_load_s) begin
            pc_nxt_s = npc_s;
        end else begin
            pc_nxt_s = pc_r;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt_s = S_IDLE;
        case (state_r)
            S_IDLE: state_nxt_s = S_REQ;
            S_REQ:  state_nxt_s = S_WAIT;
            S_WAIT: begin
                if (!rsp_s) begin
                    state_nxt_s = S_WAIT;
                end else if (hold_load_s) begin
                    state_nxt_s = S_HOLD;
                end else begin
                    state_nxt_s = S_REQ;
                end
            end
            S_HOLD: begin
                if (redirect_s || !stall_i) begin
                    state_nxt_s = S_REQ;
                end else begin
                    state_nxt_s = S_HOLD;
                end
            end
            default: state_nxt_s = S_IDLE;
        endcase
    end

    // Kill marks the in-flight response as belonging to a redirected path
    always_comb begin
        kill_nxt_s = kill_r;
        case (state_r)
            S_REQ: begin
                if (redirect_s) begin
                    kill_nxt_s = 1'b1;
                end else begin
                    kill_nxt_s = kill_r;
                end
            end
            S_WAIT: begin
                if (rsp_s) begin
                    kill_nxt_s = 1'b0;
                end else if (redirect_s) begin
                    kill_nxt_s = 1'b1;
                end else begin
                    kill_nxt_s = kill_r;
                end
            end
            S_IDLE:  kill_nxt_s = 1'b0;
            S_HOLD:  kill_nxt_s = 1'b0;
            default: kill_nxt_s = 1'b0;
        endcase
    end

    // State, PC and kill registers
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r <= S_IDLE;
            pc_r    <= RESET_PC;
            kill_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            pc_r    <= pc_nxt_s;
            kill_r  <= kill_nxt_s;
        end
    end

    // Hold buffer parks a word that arrived while decode was stalled
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            hold_valid_r <= 1'b0;
            hold_instr_r <= INSTR_W'(NOP_INSTR);
        end else begin
            hold_valid_r <= (state_nxt_s == S_HOLD);
            if (hold_load_s) begin
                hold_instr_r <= imem_rdata;
            end else begin
                hold_instr_r <= hold_instr_r;
            end
        end
    end

    // Registered request: high for exactly the cycle spent in S_REQ
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            imem_req_r  <= 1'b0;
            imem_addr_r <= RESET_PC;
        end else begin
            imem_req_r <= (state_nxt_s == S_REQ);
            if (state_nxt_s == S_REQ) begin
                imem_addr_r <= pc_nxt_s;
            end else begin
                imem_addr_r <= imem_addr_r;
            end
        end
    end

    // IF/ID register: flush beats stall, stall freezes, otherwise a bubble
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            id_valid_r <= 1'b0;
            id_instr_r <= INSTR_W'(NOP_INSTR);
            id_pc_r    <= {ADDR_W{1'b0}};
            id_pc4_r   <= {ADDR_W{1'b0}};
        end else if (redirect_s) begin
            id_valid_r <= 1'b0;
            id_instr_r <= INSTR_W'(NOP_INSTR);
        end else if (id_load_s) begin
            id_valid_r <= 1'b1;
            id_instr_r <= id_data_s;
            id_pc_r    <= pc_r;
            id_pc4_r   <= npc_s;
        end else if (stall_i) begin
            id_valid_r <= id_valid_r;
            id_instr_r <= id_instr_r;
        end else begin
            id_valid_r <= 1'b0;
            id_instr_r <= INSTR_W'(NOP_INSTR);
        end
    end

    assign imem_req  = imem_req_r;
    assign imem_addr = imem_addr_r;
    assign id_valid  = id_valid_r;
    assign id_instr  = id_instr_r;
    assign id_pc     = id_pc_r;
    assign id_pc4    = id_pc4_r;

endmodule

// File: tb/tb_mips_fetch_stage.sv
// Directed self-checking bench for mips_fetch_stage: sequential fetch, stall/hold,
// branch and jump redirects with kill, PC wrap and mid-request reset.
module tb_mips_fetch_stage;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        stall_i, br_taken_i, jmp_en_i;
    logic [31:0] br_target_i;
    logic [25:0] jmp_index_i;
    logic        imem_req, imem_rvalid, id_valid;
    logic [31:0] imem_addr, imem_rdata, id_instr, id_pc, id_pc4;

    logic        req_w, rvalid_w, valid_w;
    logic [31:0] addr_w, rdata_w, instr_w, pc_w, pc4_w;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    mips_fetch_stage dut (
        .clk(clk), .reset_n(reset_n), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .stall_i(stall_i),
        .br_taken_i(br_taken_i), .br_target_i(br_target_i), .jmp_en_i(jmp_en_i),
        .jmp_index_i(jmp_index_i), .id_valid(id_valid), .id_instr(id_instr),
        .id_pc(id_pc), .id_pc4(id_pc4)
    );

    mips_fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
        .clk(clk), .reset_n(reset_n), .imem_req(req_w), .imem_addr(addr_w),
        .imem_rvalid(rvalid_w), .imem_rdata(rdata_w), .stall_i(1'b0),
        .br_taken_i(1'b0), .br_target_i(32'h0), .jmp_en_i(1'b0),
        .jmp_index_i(26'h0), .id_valid(valid_w), .id_instr(instr_w),
        .id_pc(pc_w), .id_pc4(pc4_w)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'hC0DE_0000 ^ a;
    endfunction

    // Variable-latency memory for the main DUT, driven mid-cycle
    int          lat = 1;
    int          cnt = 0;
    logic [31:0] pend_addr = 32'h0;
    always @(negedge clk) begin
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        if (cnt > 0) begin
            cnt = cnt - 1;
            if (cnt == 0) begin
                imem_rvalid = 1'b1;
                imem_rdata  = mem_word(pend_addr);
            end
        end
        if (imem_req) begin
            cnt       = lat;
            pend_addr = imem_addr;
        end
    end

    // Fixed 1-cycle memory for the wrap-test DUT
    logic        req_w_d = 1'b0;
    logic [31:0] addr_w_d = 32'h0;
    always @(negedge clk) begin
        rvalid_w = req_w_d;
        rdata_w  = mem_word(addr_w_d);
        req_w_d  = req_w;
        addr_w_d = addr_w;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic wait_req(input string tag, output logic [31:0] addr);
        int k = 0;
        while (!imem_req && k < 40) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_req_seen"}, 32'(imem_req), 32'd1);
        addr = imem_addr;
    endtask

    task automatic wait_id(input string tag);
        int k = 0;
        while (!id_valid && k < 40) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_id_seen"}, 32'(id_valid), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        reset_n = 1'b0; stall_i = 1'b0; br_taken_i = 1'b0; jmp_en_i = 1'b0;
        br_target_i = 32'h0; jmp_index_i = 26'h0;
        repeat (3) @(negedge clk);
        check("rst_req",    32'(imem_req), 32'd0);
        check("rst_addr",   imem_addr,     32'h0);
        check("rst_valid",  32'(id_valid), 32'd0);
        check("rst_instr",  id_instr,      32'h0);
        check("rst_pc",     id_pc,         32'h0);
        check("rst_pc4",    id_pc4,        32'h0);
        check("rst_w_addr", addr_w,        32'hFFFF_FFFC);
        reset_n = 1'b1;

        // Sequential fetch with 1-cycle memory: one request every 2 cycles
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("seq_req",  32'(imem_req), 32'd1);
            check("seq_addr", imem_addr,     32'(4 * i));
            if (i > 0) begin
                check("seq_valid", 32'(id_valid), 32'd1);
                check("seq_pc",    id_pc,         32'(4 * (i - 1)));
                check("seq_instr", id_instr,      mem_word(32'(4 * (i - 1))));
                check("seq_pc4",   id_pc4,        32'(4 * i));
            end
            if (i == 0) check("wrap_first", addr_w, 32'hFFFF_FFFC);
            if (i == 1) begin
                check("wrap_second", addr_w, 32'h0);
                check("wrap_id_pc",  pc_w,   32'hFFFF_FFFC);
                check("wrap_id_pc4", pc4_w,  32'h0);
            end
            @(negedge clk);
            check("seq_req_gap", 32'(imem_req), 32'd0);
            check("seq_bubble",  32'(id_valid), 32'd0);
        end

        // Stall held 3 cycles across the response: hold buffer used
        @(negedge clk);
        check("stl_pre_addr", imem_addr, 32'd16);
        check("stl_pre_pc",   id_pc,     32'd12);
        stall_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stl_valid", 32'(id_valid), 32'd1);
            check("stl_pc",    id_pc,         32'd12);
            check("stl_instr", id_instr,      mem_word(32'd12));
            check("stl_noreq", 32'(imem_req), 32'd0);
        end
        stall_i = 1'b0;
        @(negedge clk);
        check("rel_valid", 32'(id_valid), 32'd1);
        check("rel_pc",    id_pc,         32'd16);
        check("rel_instr", id_instr,      mem_word(32'd16));
        check("rel_addr",  imem_addr,     32'd20);

        // Branch while waiting on a 3-cycle memory: flush, kill, refetch at 0x40
        @(negedge clk);
        lat = 3;
        wait_req("br", a);
        check("br_pre_addr", a, 32'd24);
        stall_i = 1'b1;
        @(negedge clk);
        br_taken_i = 1'b1; br_target_i = 32'h40;
        @(negedge clk);
        br_taken_i = 1'b0;
        check("br_flush_valid", 32'(id_valid), 32'd0);
        check("br_flush_instr", id_instr,      32'h0);
        stall_i = 1'b0;
        wait_req("br", a);
        check("br_addr", a, 32'h40);
        wait_id("br");
        check("br_id_pc",    id_pc,    32'h40);
        check("br_id_instr", id_instr, mem_word(32'h40));

        // Jump using id_pc4 = 0x1000_0008
        @(negedge clk);
        lat = 1;
        br_taken_i = 1'b1; br_target_i = 32'h1000_0004;
        @(negedge clk);
        br_taken_i = 1'b0;
        wait_req("br2", a);
        check("br2_addr", a, 32'h1000_0004);
        wait_id("br2");
        check("br2_id_pc4", id_pc4, 32'h1000_0008);
        jmp_en_i = 1'b1; jmp_index_i = 26'h000_0010;
        @(negedge clk);
        jmp_en_i = 1'b0;
        wait_req("jmp", a);
        check("jmp_addr", a, 32'h1000_0040);
        wait_id("jmp");
        check("jmp_id_pc",    id_pc,    32'h1000_0040);
        check("jmp_id_instr", id_instr, mem_word(32'h1000_0040));

        // Branch and jump together: branch wins
        br_taken_i = 1'b1; br_target_i = 32'h80;
        jmp_en_i = 1'b1; jmp_index_i = 26'h3FF_FFFF;
        @(negedge clk);
        br_taken_i = 1'b0; jmp_en_i = 1'b0;
        wait_req("prio", a);
        check("prio_addr", a, 32'h80);
        wait_id("prio");
        check("prio_id_pc", id_pc, 32'h80);

        // Reset during S_WAIT; stale response lands after release
        @(negedge clk);
        lat = 3;
        wait_req("mrst", a);
        check("mrst_pre_addr", a, 32'h88);
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        check("mrst_req",   32'(imem_req), 32'd0);
        check("mrst_addr",  imem_addr,     32'h0);
        check("mrst_valid", 32'(id_valid), 32'd0);
        check("mrst_instr", id_instr,      32'h0);
        check("mrst_pc",    id_pc,         32'h0);
        check("mrst_pc4",   id_pc4,        32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        wait_req("mrst", a);
        check("mrst_restart_addr", a, 32'h0);
        wait_id("mrst");
        check("mrst_id_pc",    id_pc,    32'h0);
        check("mrst_id_instr", id_instr, mem_word(32'h0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
